// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo
//   UART echo engine. Deserialises UART_RX, buffers the received bytes in a
//   FIFO and re-serialises them on UART_TX in acceptance order. Includes
//   a baud divider, start-bit glitch rejection, a transmit hold, sticky
//   error flags and an activity LED.
//
//   Optional feature macro: UART_ECHO_PARITY_EN
//     defined   : one even-parity bit follows the data bits on RX and TX;
//                 an RX parity mismatch sets FRAME_ERR and drops the byte.
//     undefined : frame = 1 start + DATA_BITS + 1 stop.
//
//   Parameters
//     CLK_HZ      input clock frequency in Hz
//     BAUD        line rate; DIV = (CLK_HZ + BAUD/2) / BAUD clocks per bit
//     DATA_BITS   data bits per frame (5..9), LSB first
//     FIFO_DEPTH  echo buffer entries (power of two, >= 2)
//
//   Ports
//     CLK_50MHZ   in   system clock, rising edge
//     RST_N       in   synchronous reset, active low
//     UART_RX     in   serial in, idle high, asynchronous to the clock
//     UART_TX     out  serial out, idle high, registered
//     TX_HOLD     in   1 = do not start a new TX frame
//     FIFO_LEVEL  out  entries currently buffered
//     FRAME_ERR   out  sticky: bad stop bit or parity
//     OVERFLOW    out  sticky: byte received while FIFO full
//     DBG_LED     out  registered activity indicator
module uart_echo_fifo #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          CLK_50MHZ,
  input  logic                          RST_N,
  input  logic                          UART_RX,
  output logic                          UART_TX,
  input  logic                          TX_HOLD,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
  output logic                          FRAME_ERR,
  output logic                          OVERFLOW,
  output logic                          DBG_LED
);

  localparam int DIV   = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CNT_W = $clog2(DIV);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] DIV_M1   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   LVL_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   FULL_LVL = (PTR_W + 1)'(FIFO_DEPTH);

`ifdef UART_ECHO_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

  // ---- RX synchroniser: two flops plus one for falling-edge detection
  logic rx_sync_p0, rx_sync_p1, rx_prev;

  always_ff @(posedge CLK_50MHZ) begin
    if (!RST_N) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
      rx_prev    <= 1'b1;
    end else begin
      rx_sync_p0 <= UART_RX;
      rx_sync_p1 <= rx_sync_p0;
      rx_prev    <= rx_sync_p1;
    end
  end

  // ---- RX frame FSM
  state_t                 rx_state, rx_state_nxt;
  logic [CNT_W-1:0]       rx_cnt, rx_cnt_nxt;
  logic [BIT_W-1:0]       rx_bit, rx_bit_nxt;
  logic [DATA_BITS-1:0]   rx_shreg;
  logic                   rx_shift_en, rx_par_smp, rx_push, rx_err;
  logic                   rx_par_bad;
  logic                   push_p1;

  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_cnt + CNT_ONE;
    rx_bit_nxt   = rx_bit;
    rx_shift_en  = 1'b0;
    rx_par_smp   = 1'b0;
    rx_push      = 1'b0;
    rx_err       = 1'b0;
    case (rx_state)
      S_IDLE: begin
        rx_cnt_nxt = '0;
        if (rx_prev && !rx_sync_p1) rx_state_nxt = S_START;
      end
      S_START: begin
        // Mid start bit: a line already back high was a glitch.
        if (rx_cnt == HALF_M1) begin
          rx_cnt_nxt = '0;
          rx_bit_nxt = '0;
          rx_state_nxt = rx_sync_p1 ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_cnt == DIV_M1) begin
          rx_cnt_nxt  = '0;
          rx_shift_en = 1'b1;
          if (rx_bit == LAST_BIT) rx_state_nxt = PARITY_EN ? S_PAR : S_STOP;
          else                    rx_bit_nxt   = rx_bit + BIT_ONE;
        end
      end
      S_PAR: begin
        if (rx_cnt == DIV_M1) begin
          rx_cnt_nxt   = '0;
          rx_par_smp   = 1'b1;
          rx_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (rx_cnt == DIV_M1) begin
          rx_cnt_nxt   = '0;
          rx_state_nxt = S_IDLE;
          if (rx_sync_p1 && !rx_par_bad) rx_push = 1'b1;
          else                           rx_err  = 1'b1;
        end
      end
      default: rx_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (!RST_N) begin
      rx_state   <= S_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_par_bad <= 1'b0;
      push_p1    <= 1'b0;
      FRAME_ERR  <= 1'b0;
    end else begin
      rx_state <= rx_state_nxt;
      rx_cnt   <= rx_cnt_nxt;
      rx_bit   <= rx_bit_nxt;
      push_p1  <= rx_push;
      if (rx_par_smp) rx_par_bad <= rx_sync_p1 ^ even_parity(rx_shreg);
      if (rx_err)     FRAME_ERR  <= 1'b1;
    end
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (rx_shift_en) rx_shreg <= {rx_sync_p1, rx_shreg[DATA_BITS-1:1]};
  end

  // ---- FIFO: push lands one cycle after the stop sample
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [PTR_W:0]       level;
  logic                 full, wr_en, tx_pop;

  assign full       = (level == FULL_LVL);
  // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
  assign wr_en      = push_p1 && (!full || tx_pop);
  assign FIFO_LEVEL = level;

  always_ff @(posedge CLK_50MHZ) begin
    if (!RST_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + PTR_ONE;
      if (tx_pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, tx_pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
      if (push_p1 && full && !tx_pop) OVERFLOW <= 1'b1;
    end
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (wr_en) mem[wr_ptr] <= rx_shreg;
  end

  // ---- TX frame FSM; the line register adds one cycle after the state
  state_t                 tx_state, tx_state_nxt;
  logic [CNT_W-1:0]       tx_cnt, tx_cnt_nxt;
  logic [BIT_W-1:0]       tx_bit, tx_bit_nxt;
  logic [DATA_BITS-1:0]   tx_shreg;
  logic                   tx_par, tx_shift_en, tx_line;

  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt + CNT_ONE;
    tx_bit_nxt   = tx_bit;
    tx_pop       = 1'b0;
    tx_shift_en  = 1'b0;
    tx_line      = 1'b1;
    case (tx_state)
      S_IDLE: begin
        tx_cnt_nxt = '0;
        if (level != '0 && !TX_HOLD) begin
          tx_pop       = 1'b1;
          tx_state_nxt = S_START;
        end
      end
      S_START: begin
        tx_line = 1'b0;
        if (tx_cnt == DIV_M1) begin
          tx_cnt_nxt   = '0;
          tx_bit_nxt   = '0;
          tx_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        tx_line = tx_shreg[0];
        if (tx_cnt == DIV_M1) begin
          tx_cnt_nxt  = '0;
          tx_shift_en = 1'b1;
          if (tx_bit == LAST_BIT) tx_state_nxt = PARITY_EN ? S_PAR : S_STOP;
          else                    tx_bit_nxt   = tx_bit + BIT_ONE;
        end
      end
      S_PAR: begin
        tx_line = tx_par;
        if (tx_cnt == DIV_M1) begin
          tx_cnt_nxt   = '0;
          tx_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (tx_cnt == DIV_M1) begin
          tx_cnt_nxt   = '0;
          tx_state_nxt = S_IDLE;
        end
      end
      default: tx_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (!RST_N) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      UART_TX  <= 1'b1;
      DBG_LED  <= 1'b0;
    end else begin
      tx_state <= tx_state_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_bit   <= tx_bit_nxt;
      UART_TX  <= tx_line;
      DBG_LED  <= (rx_state != S_IDLE) || (tx_state != S_IDLE) || (level != '0);
    end
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (tx_pop) begin
      tx_shreg <= mem[rd_ptr];
      tx_par   <= even_parity(mem[rd_ptr]);
    end else if (tx_shift_en) begin
      tx_shreg <= tx_shreg >> 1;
    end
  end

endmodule
